// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: drives the BRAM 4-word window and buffers words in a circular queue.
// Optional `FETCH_STATS_EN adds saturating pop and full-stall counters.
module inst_fetch_queue #(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned QDEPTH    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PC_W-1:0] start_pc,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     fetch_addr,
    input  logic [31:0]     win0,
    input  logic [31:0]     win1,
    input  logic [31:0]     win2,
    input  logic [31:0]     win3,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [PC_W-1:0] inst_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_stall,
`endif
    output logic            busy
);

    localparam int unsigned QW = $clog2(QDEPTH);
    localparam logic [PC_W:0] MEM_WORDS = (PC_W+1)'(1) << PC_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [QW:0]     count_q, count_d;
    logic [QW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [QW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     word_q [QDEPTH];
    logic [PC_W-1:0] wpc_q  [QDEPTH];

    logic [31:0]     win [4];
    logic [QW:0]     free;
    logic [PC_W:0]   room;
    logic [2:0]      n_room;
    logic [2:0]      n_enq;
    logic            halt_hit;
    logic            pop;

    assign win[0] = win0;
    assign win[1] = win1;
    assign win[2] = win2;
    assign win[3] = win3;

    assign inst_valid = (count_q != '0);
    assign inst       = word_q[rd_ptr_q];
    assign inst_pc    = wpc_q[rd_ptr_q];
    assign busy       = (state_q != ST_IDLE);
    assign fetch_addr = {{(32-PC_W){1'b0}}, fetch_pc_q};
    assign pop        = inst_valid & inst_ready;

    // Window size: limited by queue space (no credit for a same-cycle pop) and top of memory.
    always_comb begin
        free     = (QW+1)'(QDEPTH) - count_q;
        room     = MEM_WORDS - {1'b0, fetch_pc_q};
        n_room   = 3'd4;
        if (free < (QW+1)'(4)) n_room = free[2:0];
        if (room < (PC_W+1)'(n_room)) n_room = room[2:0];
        n_enq    = n_room;
        halt_hit = 1'b0;
        // Descending scan so the lowest-indexed halt word wins.
        for (int k = 3; k >= 0; k--) begin
            if (3'(k) < n_room && win[k] == HALT_WORD) begin
                halt_hit = 1'b1;
                n_enq    = 3'(k + 1);
            end
        end
        if (state_q != ST_FETCH || redirect) begin
            n_enq    = 3'd0;
            halt_hit = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q + (QW+1)'(n_enq) - (QW+1)'(pop);
        rd_ptr_d   = rd_ptr_q + QW'(pop);
        wr_ptr_d   = wr_ptr_q + QW'(n_enq);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    fetch_pc_d = start_pc;
                end
            end
            ST_FETCH: begin
                if (halt_hit) state_d = ST_DRAIN;
                else          fetch_pc_d = fetch_pc_q + PC_W'(n_enq);
            end
            ST_DRAIN: begin
                if (count_q == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (redirect) begin
            state_d    = ST_FETCH;
            fetch_pc_d = redirect_pc;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                word_q[i] <= '0;
                wpc_q[i]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < n_enq) begin
                    word_q[wr_ptr_q + QW'(k)] <= win[k];
                    wpc_q[wr_ptr_q + QW'(k)]  <= fetch_pc_q + PC_W'(k);
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_q, stat_stall_q;
    logic        stat_clr;

    assign stat_clr     = start & (state_q == ST_IDLE) & ~redirect;
    assign stat_fetched = stat_fetched_q;
    assign stat_stall   = stat_stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched_q <= '0;
            stat_stall_q   <= '0;
        end else if (stat_clr) begin
            stat_fetched_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            if (pop && stat_fetched_q != 32'hFFFF_FFFF) stat_fetched_q <= stat_fetched_q + 32'd1;
            if (state_q == ST_FETCH && free == '0 && stat_stall_q != 32'hFFFF_FFFF)
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end
`endif

endmodule
